// File: rtl/dest_header_inserter.sv
// Prepends a 64-bit destination header (the first beat's tdest) to each AXI-Stream frame.
// The payload moves up by 8 bytes, so the top 64 bits of each beat carry into the next output beat.
//
// state | meaning
// FIRST | waiting for the first beat of a frame; the carry source is the header
// BODY  | mid-frame; the carry holds the previous beat's top 64 bits
// TAIL  | the last input beat overflowed, so the residual carry is emitted as its own beat
module dest_header_inserter #(
  parameter int DATA_WIDTH   = 64,
  parameter int STRB_WIDTH   = DATA_WIDTH/8,
  parameter int CORE_WIDTH   = 4,
  parameter int ID_TAG_WIDTH = 5+CORE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [STRB_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [ID_TAG_WIDTH-1:0] s_axis_tdest,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [STRB_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);

  typedef enum logic [1:0] {FIRST, BODY, TAIL} state_t;

  state_t                  state, state_next;
  logic [63:0]             carry;
  logic [7:0]              carry_keep;
  logic [63:0]             hdr, cur_carry;
  logic [7:0]              cur_carry_keep;
  logic [DATA_WIDTH-1:0]   beat_data;
  logic [STRB_WIDTH-1:0]   beat_keep;
  logic                    out_ready, s_accept, load, top_keep_nz;

  assign out_ready      = !m_axis_tvalid || m_axis_tready;
  // The rst_n term holds tready low while the block is in reset.
  assign s_axis_tready  = rst_n && (state != TAIL) && out_ready;
  assign s_accept       = s_axis_tvalid && s_axis_tready;
  assign load           = (s_accept || state == TAIL) && out_ready;
  assign hdr            = 64'(s_axis_tdest);
  assign cur_carry      = (state == FIRST) ? hdr : carry;
  assign cur_carry_keep = (state == FIRST) ? 8'hFF : carry_keep;
  assign top_keep_nz    = |s_axis_tkeep[STRB_WIDTH-1 -: 8];

  generate
    if (DATA_WIDTH == 64) begin : g_narrow
      assign beat_data = cur_carry;
      assign beat_keep = cur_carry_keep;
    end else begin : g_wide
      assign beat_data = {s_axis_tdata[DATA_WIDTH-65:0], cur_carry};
      assign beat_keep = {s_axis_tkeep[STRB_WIDTH-9:0], cur_carry_keep};
    end
  endgenerate

  always_comb begin
    state_next = state;
    case (state)
      FIRST, BODY: begin
        if (s_accept) begin
          if (!s_axis_tlast)    state_next = BODY;
          else if (top_keep_nz) state_next = TAIL;
          else                  state_next = FIRST;
        end
      end
      TAIL:    if (out_ready) state_next = FIRST;
      default: state_next = FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FIRST;
      carry         <= '0;
      carry_keep    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        m_axis_tvalid <= 1'b1;
        if (state == TAIL) begin
          m_axis_tdata <= DATA_WIDTH'(carry);
          m_axis_tkeep <= STRB_WIDTH'(carry_keep);
          m_axis_tlast <= 1'b1;
        end else begin
          m_axis_tdata <= beat_data;
          m_axis_tkeep <= beat_keep;
          m_axis_tlast <= s_axis_tlast && !top_keep_nz;
          carry        <= s_axis_tdata[DATA_WIDTH-1 -: 64];
          carry_keep   <= s_axis_tkeep[STRB_WIDTH-1 -: 8];
        end
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dest_header_inserter.sv
// Bench for dest_header_inserter: directed cases on 64- and 128-bit instances, plus random
// frames on the 128-bit instance checked against a byte-stream reference model.
module tb_dest_header_inserter;
  localparam int TW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [63:0]   a_s_tdata;  logic [7:0]  a_s_tkeep;  logic a_s_tvalid, a_s_tlast, a_s_tready;
  logic [TW-1:0] a_s_tdest;
  logic [63:0]   a_m_tdata;  logic [7:0]  a_m_tkeep;  logic a_m_tvalid, a_m_tlast, a_m_tready;
  logic [127:0]  b_s_tdata;  logic [15:0] b_s_tkeep;  logic b_s_tvalid, b_s_tlast, b_s_tready;
  logic [TW-1:0] b_s_tdest;
  logic [127:0]  b_m_tdata;  logic [15:0] b_m_tkeep;  logic b_m_tvalid, b_m_tlast, b_m_tready;

  int n_cmp = 0;
  int n_bad = 0;

  dest_header_inserter #(.DATA_WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_s_tkeep), .s_axis_tvalid(a_s_tvalid),
    .s_axis_tlast(a_s_tlast), .s_axis_tdest(a_s_tdest), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_tkeep(a_m_tkeep), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tlast(a_m_tlast), .m_axis_tready(a_m_tready)
  );

  dest_header_inserter #(.DATA_WIDTH(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(b_s_tdata), .s_axis_tkeep(b_s_tkeep), .s_axis_tvalid(b_s_tvalid),
    .s_axis_tlast(b_s_tlast), .s_axis_tdest(b_s_tdest), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tlast(b_m_tlast), .m_axis_tready(b_m_tready)
  );

  task automatic idle();
    a_s_tvalid = 0; a_s_tlast = 0; a_s_tdata = '0; a_s_tkeep = '0; a_s_tdest = '0; a_m_tready = 1;
    b_s_tvalid = 0; b_s_tlast = 0; b_s_tdata = '0; b_s_tkeep = '0; b_s_tdest = '0; b_m_tready = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata, a_s_tready} !== '0) begin
      n_bad++;
      $display("FAIL reset_dw64: got v=%b l=%b k=%h d=%h rdy=%b want all zero",
               a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata, a_s_tready);
    end
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata, b_s_tready} !== '0) begin
      n_bad++;
      $display("FAIL reset_dw128: got v=%b l=%b k=%h d=%h rdy=%b want all zero",
               b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata, b_s_tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({a_s_tready, b_s_tready} !== 2'b11) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b want 11", {a_s_tready, b_s_tready});
    end
  endtask

  task automatic test_dw64_frame();
    @(negedge clk);
    a_s_tdest = 9'h1A5; a_s_tdata = 64'h1111_1111_1111_1111; a_s_tkeep = 8'hFF;
    a_s_tlast = 0; a_s_tvalid = 1;
    #1;
    n_cmp++;
    if (a_s_tready !== 1'b1) begin n_bad++; $display("FAIL dw64_ready0: got %b want 1", a_s_tready); end
    @(negedge clk);
    a_s_tdest = 9'h0AA; a_s_tdata = 64'h2222_2222_2222_2222; a_s_tlast = 1;
    #1;
    n_cmp++;
    if ({a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata} !== {1'b1, 1'b0, 8'hFF, 64'h1A5}) begin
      n_bad++;
      $display("FAIL dw64_hdr: got %h want %h", {a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata},
               {1'b1, 1'b0, 8'hFF, 64'h1A5});
    end
    @(negedge clk);
    a_s_tvalid = 0;
    #1;
    n_cmp++;
    if ({a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata, a_s_tready} !==
        {1'b1, 1'b0, 8'hFF, 64'h1111_1111_1111_1111, 1'b0}) begin
      n_bad++;
      $display("FAIL dw64_beat1: got %h rdy=%b want 2ff1111111111111111 rdy=0",
               {a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata}, a_s_tready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata, a_s_tready} !==
        {1'b1, 1'b1, 8'hFF, 64'h2222_2222_2222_2222, 1'b1}) begin
      n_bad++;
      $display("FAIL dw64_tail: got %h rdy=%b want 3ff2222222222222222 rdy=1",
               {a_m_tvalid, a_m_tlast, a_m_tkeep, a_m_tdata}, a_s_tready);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (a_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL dw64_drain: got valid %b want 0", a_m_tvalid); end
  endtask

  task automatic test_single_beat();
    logic [63:0] d;
    d = {$urandom, $urandom};
    @(negedge clk);
    b_s_tdata = {64'h0, d}; b_s_tkeep = 16'h00FF; b_s_tdest = 9'h003; b_s_tlast = 1; b_s_tvalid = 1;
    @(negedge clk);
    b_s_tvalid = 0;
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata} !== {1'b1, 1'b1, 16'hFFFF, d, 64'h3}) begin
      n_bad++;
      $display("FAIL single_beat: got %h want %h", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               {1'b1, 1'b1, 16'hFFFF, d, 64'h3});
    end
    n_cmp++;
    if (b_s_tready !== 1'b1) begin n_bad++; $display("FAIL single_no_tail: got ready %b want 1", b_s_tready); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (b_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got valid %b want 0", b_m_tvalid); end
  endtask

  task automatic test_tail_beat();
    logic [95:0] d;
    d = {$urandom, $urandom, $urandom};
    @(negedge clk);
    b_s_tdata = {32'h0, d}; b_s_tkeep = 16'h0FFF; b_s_tdest = 9'h007; b_s_tlast = 1; b_s_tvalid = 1;
    @(negedge clk);
    b_s_tvalid = 0;
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata, b_s_tready} !==
        {1'b1, 1'b0, 16'hFFFF, d[63:0], 64'h7, 1'b0}) begin
      n_bad++;
      $display("FAIL tail_first: got %h rdy=%b want %h rdy=0", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               b_s_tready, {1'b1, 1'b0, 16'hFFFF, d[63:0], 64'h7});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata} !== {1'b1, 1'b1, 16'h000F, 96'h0, d[95:64]}) begin
      n_bad++;
      $display("FAIL tail_second: got %h want %h", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               {1'b1, 1'b1, 16'h000F, 96'h0, d[95:64]});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (b_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL tail_drain: got valid %b want 0", b_m_tvalid); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] d1, d2;
    d1 = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    b_s_tdata = d1; b_s_tkeep = 16'hFFFF; b_s_tdest = 9'h005; b_s_tlast = 1; b_s_tvalid = 1;
    @(negedge clk);
    b_s_tdata = d2; b_s_tdest = 9'h009;
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata, b_s_tready} !==
        {1'b1, 1'b0, 16'hFFFF, d1[63:0], 64'h5, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_hdr5: got %h rdy=%b want %h rdy=0", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               b_s_tready, {1'b1, 1'b0, 16'hFFFF, d1[63:0], 64'h5});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata, b_s_tready} !==
        {1'b1, 1'b1, 16'h00FF, 64'h0, d1[127:64], 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_tail1: got %h rdy=%b want %h rdy=1", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               b_s_tready, {1'b1, 1'b1, 16'h00FF, 64'h0, d1[127:64]});
    end
    @(negedge clk);
    b_s_tvalid = 0;
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata} !== {1'b1, 1'b0, 16'hFFFF, d2[63:0], 64'h9}) begin
      n_bad++;
      $display("FAIL b2b_hdr9: got %h want %h", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               {1'b1, 1'b0, 16'hFFFF, d2[63:0], 64'h9});
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata} !== {1'b1, 1'b1, 16'h00FF, 64'h0, d2[127:64]}) begin
      n_bad++;
      $display("FAIL b2b_tail2: got %h want %h", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               {1'b1, 1'b1, 16'h00FF, 64'h0, d2[127:64]});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [127:0] d;
    @(negedge clk);
    b_s_tdata = {4{32'hAAAA_5555}}; b_s_tkeep = 16'hFFFF; b_s_tdest = 9'h011; b_s_tlast = 0; b_s_tvalid = 1;
    @(negedge clk);
    b_s_tdata = {4{32'h3333_CCCC}};
    @(negedge clk);
    rst_n = 1'b0;
    b_s_tvalid = 0;
    #1;
    n_cmp++;
    if (b_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", b_m_tvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_s_tready} !== 2'b01) begin
      n_bad++;
      $display("FAIL midreset_release: got valid/ready %b want 01", {b_m_tvalid, b_s_tready});
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    b_s_tdata = d; b_s_tdest = 9'h015; b_s_tlast = 1; b_s_tvalid = 1;
    @(negedge clk);
    b_s_tvalid = 0;
    #1;
    n_cmp++;
    if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata} !== {1'b1, 1'b0, 16'hFFFF, d[63:0], 64'h15}) begin
      n_bad++;
      $display("FAIL midreset_newhdr: got %h want %h", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata},
               {1'b1, 1'b0, 16'hFFFF, d[63:0], 64'h15});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random(input int nframes);
    logic [127:0] exp_d[$];
    logic [15:0]  exp_k[$];
    logic         exp_l[$];
    logic [127:0] in_d[$];
    logic [15:0]  in_k[$];
    logic [7:0]   bytes[$];
    logic [TW-1:0] dest;
    logic [127:0] d;
    logic [15:0]  k;
    logic [7:0]   by;
    logic [145:0] held;
    logic         stalled, first_beat;
    int           sent, cycles, nb, lastn, n;
    stalled = 0; first_beat = 1; sent = 0; cycles = 0; dest = '0; held = '0;
    @(negedge clk);
    while ((sent < nframes || in_d.size() != 0 || exp_d.size() != 0) && cycles < 40000) begin
      if (in_d.size() == 0 && sent < nframes) begin
        nb = $urandom_range(1, 4);
        lastn = $urandom_range(1, 16);
        dest = TW'($urandom);
        bytes.delete();
        for (int i = 0; i < 8; i++) bytes.push_back(8'(64'(dest) >> (8*i)));
        for (int b = 0; b < nb; b++) begin
          n = (b == nb-1) ? lastn : 16;
          d = '0; k = '0;
          for (int i = 0; i < n; i++) begin
            by = 8'($urandom);
            d[8*i +: 8] = by;
            k[i] = 1'b1;
            bytes.push_back(by);
          end
          in_d.push_back(d);
          in_k.push_back(k);
        end
        // Expected output: header bytes followed by payload bytes, repacked 16 per beat.
        for (int off = 0; off < bytes.size(); off += 16) begin
          d = '0; k = '0;
          for (int i = 0; i < 16 && off+i < bytes.size(); i++) begin
            d[8*i +: 8] = bytes[off+i];
            k[i] = 1'b1;
          end
          exp_d.push_back(d);
          exp_k.push_back(k);
          exp_l.push_back(off + 16 >= bytes.size());
        end
        sent++;
        first_beat = 1;
      end
      b_s_tvalid = (in_d.size() != 0) && ($urandom_range(0, 3) != 0);
      if (in_d.size() != 0) begin
        b_s_tdata = in_d[0];
        b_s_tkeep = in_k[0];
        b_s_tlast = (in_d.size() == 1);
        b_s_tdest = first_beat ? dest : TW'($urandom);
      end
      b_m_tready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        n_cmp++;
        if ({b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata} !== held) begin
          n_bad++;
          $display("FAIL rand_stall_hold: got %h want %h", {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata}, held);
        end
      end
      stalled = b_m_tvalid && !b_m_tready;
      held = {b_m_tvalid, b_m_tlast, b_m_tkeep, b_m_tdata};
      if (b_m_tvalid && b_m_tready) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_bad++;
          $display("FAIL rand_extra_beat: got %h want no beat", b_m_tdata);
        end else begin
          if ({b_m_tlast, b_m_tkeep, b_m_tdata} !== {exp_l[0], exp_k[0], exp_d[0]}) begin
            n_bad++;
            $display("FAIL rand_beat: got l=%b k=%h d=%h want l=%b k=%h d=%h",
                     b_m_tlast, b_m_tkeep, b_m_tdata, exp_l[0], exp_k[0], exp_d[0]);
          end
          void'(exp_d.pop_front());
          void'(exp_k.pop_front());
          void'(exp_l.pop_front());
        end
      end
      if (b_s_tvalid && b_s_tready) begin
        void'(in_d.pop_front());
        void'(in_k.pop_front());
        first_beat = 0;
      end
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end
    n_cmp++;
    if (cycles >= 40000) begin
      n_bad++;
      $display("FAIL rand_timeout: got %0d beats outstanding want 0", exp_d.size());
    end
    idle();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (b_m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rand_no_extra: got valid %b want 0", b_m_tvalid); end
  endtask

  initial begin
    test_reset();
    test_dw64_frame();
    test_single_beat();
    test_tail_beat();
    test_back_to_back();
    test_reset_midframe();
    test_random(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
